ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, attached beside the EX-stage ALU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. Raises a stall request so the pipeline controller holds the issuing instruction in EX until the result is written.
- MTHI/MTLO write HI/LO in a single cycle.
- Parametrised in datapath width.

Parameters:
- DATA_W, 32: operand, HI and LO width. Must be even and at least 8.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort the in-flight operation; HI/LO are left unchanged
- op_valid  in  1  the instruction in EX is a mul/div/mthi/mtlo op
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops
- src_a  in  DATA_W  rs value (dividend or multiplicand; MTHI/MTLO source)
- src_b  in  DATA_W  rt value (divisor or multiplier)
- stallreq  out  1  hold IF/ID/EX; combinational
- busy  out  1  state is not IDLE
- hi  out  DATA_W  architectural HI
- lo  out  DATA_W  architectural LO
- hilo_we  out  1  pulses high in the cycle HI/LO load at the next edge

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, counter=0, stallreq=0, busy=0, hilo_we=0. Reset overrides flush and op_valid.
- States: IDLE, RUN, DONE.
- IDLE:
  - op_valid with op 0-3: stallreq=1 in this cycle (combinational). Latch operand magnitudes and sign flags. Go to RUN with counter=0.
  - op_valid with op 4/5: hilo_we=1; hi (op 4) or lo (op 5) takes src_a at this edge; no stall.
  - op 6/7 or op_valid=0: nothing happens.
- RUN: one iteration per cycle, stallreq=1, counter increments.
  - Multiply: shift-add over the DATA_W-bit magnitudes into a 2*DATA_W accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - After DATA_W iterations (counter==DATA_W-1 at the edge), go to DONE.
- Divide by zero (divisor==0): RUN is skipped and the FSM goes IDLE->DONE directly. Result is quotient all-ones, remainder equal to the dividend; signed variants apply no sign fixup.
- DONE:
  - stallreq=0 and hilo_we=1.
  - Multiply result: hi takes the upper half, lo the lower half.
  - Divide result: lo takes the quotient, hi the remainder.
  - Return to IDLE. The held instruction's op_valid in DONE is ignored and does not restart the operation.
- Signed fixup:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Most-negative / -1: quotient wraps to the most-negative value, remainder=0.
- Latency from acceptance in IDLE: stallreq is high for DATA_W+1 cycles (33 at default). HI/LO are updated at the edge ending DONE, i.e. cycle DATA_W+1.
- flush in any state: next state IDLE, hilo_we forced 0, HI/LO unchanged. flush in DONE suppresses the write.
- op and operands are sampled only on acceptance; changes during RUN are ignored.
- hi/lo are purely registered outputs. A consumer in the same cycle as hilo_we sees the old value; bypass is the consumer's responsibility.

Optional Feature:
- Macro: EX_MULDIV_FAST_MUL_EN.
- When defined: MULT/MULTU use a single-cycle combinational product registered in IDLE, then go to DONE. stallreq is high for 1 cycle and HI/LO update 2 cycles after acceptance.
- Divide behaviour is unchanged.
- When undefined: iterative shift-add multiply as above.

Test Plan:
- Reset, then MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF: stallreq high for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- MULT src_a=-3 (0xFFFFFFFD), src_b=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV src_a=-7, src_b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7: lo=14, hi=2.
- DIVU src_a=0x1234, src_b=0: stallreq high for exactly 1 cycle; lo=0xFFFFFFFF, hi=0x1234.
- Start DIV with hi=0xAA, lo=0xBB, assert flush on RUN cycle 10: busy=0 next cycle, hi=0xAA, lo=0xBB. A following MTLO 0x55 writes lo=0x55 in one cycle with stallreq=0.
- Assert rst mid-RUN: next cycle state=IDLE, hi=lo=0, stallreq=0. Then DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the EX stage and the ex_muldiv unit.
// The pipeline side is the master; the mul/div unit is the slave.
interface ex_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              op_valid;
    logic [2:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              stallreq;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              hilo_we;

    modport master (
        output flush, op_valid, op, src_a, src_b,
        input  stallreq, busy, hi, lo, hilo_we
    );

    modport slave (
        input  flush, op_valid, op, src_a, src_b,
        output stallreq, busy, hi, lo, hilo_we
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Define EX_MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting; accepts mul/div ops, performs MTHI/MTLO writes
// RUN     | one shift-add or restoring-divide step per cycle
// DONE    | sign fixup, HI/LO written at the closing edge
module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;

    logic                stallreq_c;
    logic                hilo_we_c;

    logic                op_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic                accept;
    logic                mt_wr;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] div_next;

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    // op[0] clear selects the signed variants, op[1] selects divide
    assign op_signed = !bus.op[0];
    assign a_neg     = op_signed && bus.src_a[DATA_W-1];
    assign b_neg     = op_signed && bus.src_b[DATA_W-1];
    assign mag_a     = a_neg ? -bus.src_a : bus.src_a;
    assign mag_b     = b_neg ? -bus.src_b : bus.src_b;

    assign accept = (state_q == ST_IDLE) && bus.op_valid && !bus.op[2] && !bus.flush;
    assign mt_wr  = (state_q == ST_IDLE) && bus.op_valid && (bus.op[2:1] == 2'b10) && !bus.flush;

`ifdef EX_MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_prod = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`endif

    // Multiply: multiplier sits in the low half and is shifted out as partial sums come in.
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : {(DATA_W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // Restoring divide: {remainder, dividend/quotient} shifted left one bit per step.
    assign rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_diff = rem_sh - {1'b0, b_q};
    assign div_ge   = (rem_sh >= {1'b0, b_q});
    assign div_next = div_ge ? {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1}
                             : {rem_sh[DATA_W-1:0],   acc_q[DATA_W-2:0], 1'b0};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quot_fix = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        b_d        = b_q;
        acc_d      = acc_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        stallreq_c = 1'b0;
        hilo_we_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stallreq_c = 1'b1;
                    is_div_d   = bus.op[1];
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    b_d        = mag_b;
                    cnt_d      = '0;
                    if (bus.op[1] && (bus.src_b == '0)) begin
                        // Divide by zero: raw dividend as remainder, all-ones quotient, no fixup.
                        acc_d     = {bus.src_a, {DATA_W{1'b1}}};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = ST_DONE;
                    end else if (bus.op[1]) begin
                        acc_d   = {{DATA_W{1'b0}}, mag_a};
                        state_d = ST_RUN;
                    end else begin
`ifdef EX_MULDIV_FAST_MUL_EN
                        acc_d   = fast_prod;
                        state_d = ST_DONE;
`else
                        acc_d   = {{DATA_W{1'b0}}, mag_a};
                        state_d = ST_RUN;
`endif
                    end
                end else if (mt_wr) begin
                    hilo_we_c = 1'b1;
                    if (bus.op[0]) begin
                        lo_d = bus.src_a;
                    end else begin
                        hi_d = bus.src_a;
                    end
                end
            end
            ST_RUN: begin
                stallreq_c = 1'b1;
                acc_d      = is_div_q ? div_next : mul_next;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hilo_we_c = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d   = ST_IDLE;
            hilo_we_c = 1'b0;
            hi_d      = hi_q;
            lo_d      = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.stallreq = stallreq_c && !rst;
    assign bus.hilo_we  = hilo_we_c && !rst;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus queues expected {hi,lo}; a monitor
// checks them after every hilo_we pulse.
module tb_ex_muldiv;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_W(32)) bus ();

    ex_muldiv #(
        .DATA_W(32),
        .CNT_W (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    string       name_q[$];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued expectation.
    initial begin
        logic [63:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (bus.hilo_we === 1'b1) begin
                @(posedge clk);
                #1;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got hi=%h lo=%h expected no write", bus.hi, bus.lo);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if ({bus.hi, bus.lo} !== e) begin
                        bad++;
                        $display("FAIL %s_hilo: got hi=%h lo=%h expected hi=%h lo=%h",
                                 nm, bus.hi, bus.lo, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        exp_q.push_back({exp_hi, exp_lo});
        name_q.push_back(nm);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stallreq) break;
            n++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op       = 3'd6;
        check_int({nm, "_stall"}, n, exp_stall);
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
    endtask

    initial begin
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 3'd6;
        bus.src_a    = '0;
        bus.src_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check32("rst_hi", bus.hi, 32'h0);
        check32("rst_lo", bus.lo, 32'h0);
        check_int("rst_busy", int'(bus.busy), 0);
        check_int("rst_stallreq", int'(bus.stallreq), 0);
        check_int("rst_hilo_we", int'(bus.hilo_we), 0);

        do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALL, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'h0000_0007, MUL_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mult_nn",   3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, MUL_STALL, 32'h0000_0000, 32'h0000_001E);
        do_op("div_neg_a", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, DIV_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_neg_b", 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, DIV_STALL, 32'h0000_0001, 32'hFFFF_FFFD);
        do_op("divu",      3'd3, 32'd100,       32'd7,         DIV_STALL, 32'd2,         32'd14);
        do_op("divu_zero", 3'd3, 32'h0000_1234, 32'h0,         1,         32'h0000_1234, 32'hFFFF_FFFF);
        do_op("div_zero",  3'd2, 32'hFFFF_FFF9, 32'h0,         1,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        do_op("mthi",      3'd4, 32'h0000_00AA, 32'h0,         0,         32'h0000_00AA, 32'hFFFF_FFFF);
        do_op("mtlo",      3'd5, 32'h0000_00BB, 32'h0,         0,         32'h0000_00AA, 32'h0000_00BB);

        // Flush on the 10th RUN cycle: no write, unit idle next cycle.
        start_op(3'd2, 32'hFFFF_FFF9, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        check_int("flush_run_busy_before", int'(bus.busy), 1);
        bus.flush    = 1'b1;
        bus.op_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check_int("flush_run_busy", int'(bus.busy), 0);
        check_int("flush_run_stallreq", int'(bus.stallreq), 0);
        check32("flush_run_hi", bus.hi, 32'h0000_00AA);
        check32("flush_run_lo", bus.lo, 32'h0000_00BB);
        repeat (3) @(posedge clk);
        do_op("mtlo_after_flush", 3'd5, 32'h0000_0055, 32'h0, 0, 32'h0000_00AA, 32'h0000_0055);

        // Flush in DONE suppresses the write.
        start_op(3'd3, 32'd100, 32'd7);
        repeat (DIV_STALL) @(posedge clk);
        #1;
        check_int("flush_done_stallreq", int'(bus.stallreq), 0);
        check_int("flush_done_busy", int'(bus.busy), 1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        check_int("flush_done_busy_after", int'(bus.busy), 0);
        check32("flush_done_hi", bus.hi, 32'h0000_00AA);
        check32("flush_done_lo", bus.lo, 32'h0000_0055);

        // Reset in the middle of RUN.
        start_op(3'd2, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.op_valid = 1'b0;
        check_int("rst_run_busy", int'(bus.busy), 0);
        check_int("rst_run_stallreq", int'(bus.stallreq), 0);
        check32("rst_run_hi", bus.hi, 32'h0);
        check32("rst_run_lo", bus.lo, 32'h0);

        do_op("div_minneg", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_STALL, 32'h0000_0000, 32'h8000_0000);

        repeat (4) @(posedge clk);
        #1;
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
